// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR bank: width limit, maximal tap masks,
// control FSM states and the per-channel seed derivation.
package lfsr_pkg;

  localparam int MAX_W = 64;

  // Maximal-length Fibonacci tap masks (bit i set = state[i] tapped).
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'hA3000000;
  localparam logic [63:0] TAPS_W64 = 64'hD800000000000000;

  // Control FSM: free-running warm-up, then enable-driven run.
  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } lfsr_state_e;

  // Reset seed of channel ch before truncation to the LFSR width.
  function automatic logic [MAX_W-1:0] chan_seed(input logic [MAX_W-1:0] seed,
                                                 input logic [MAX_W-1:0] stride,
                                                 input int               ch);
    return seed ^ (MAX_W'(ch) * stride);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// One Fibonacci LFSR channel: reset seed, step, external load and
// all-zero lockup recovery with a sticky flag.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W64[WIDTH-1:0],
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             step,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  // An all-zero seed would freeze the register, so it is replaced by 1.
  localparam logic [WIDTH-1:0] RESET_VAL = (SEED == '0) ? WIDTH'(1) : SEED;

  logic fb;

  assign fb = ^(state & TAPS);

  // Channel register: load beats step; a zero state recovers to 1 and flags lockup.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!nRST) begin
      state  <= RESET_VAL;
      lockup <= 1'b0;
    end else if (load) begin
      state  <= (load_data == '0) ? WIDTH'(1) : load_data;
      lockup <= 1'b0;
    end else if (step) begin
      if (state == '0) begin
        state  <= WIDTH'(1);
        lockup <= 1'b1;
      end else begin
        state <= {state[WIDTH-2:0], fb};
      end
    end
  end

endmodule

// File: rtl/lfsr_bank.sv
// Bank of NUM_CH independent LFSRs feeding stochastic number generators.
// Owns the warm-up/run FSM, the warm-up counter and the reseed decode.
module lfsr_bank
  import lfsr_pkg::*;
#(
  parameter int          WIDTH       = 64,
  parameter int          NUM_CH      = 4,
  parameter logic [63:0] TAPS        = 64'hD800000000000000,
  parameter logic [63:0] SEED        = 64'hFEEDBABEDEADBEEF,
  parameter logic [63:0] SEED_STRIDE = 64'h9E3779B97F4A7C15,
  parameter int          WARMUP      = 16,
  localparam int         SCH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    en,
  input  logic                    seed_valid,
  input  logic [SCH_W-1:0]        seed_ch,
  input  logic [WIDTH-1:0]        seed_data,
  output logic                    seed_ready,
  output logic                    valid,
  output logic [NUM_CH*WIDTH-1:0] r,
  output logic [NUM_CH-1:0]       bits,
  output logic [NUM_CH-1:0]       lockup
);

  // Counter only has to hold 0..WARMUP-1.
  localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  lfsr_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_all;
  logic             accept;

  assign accept = seed_valid && seed_ready;

  // FSM state and warm-up counter registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ST_WARMUP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control decode: warm-up free-runs, run follows en.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid      = 1'b0;
    seed_ready = 1'b0;
    step_all   = 1'b0;
    case (state_q)
      ST_WARMUP: begin
        if (WARMUP == 0) begin
          state_d = ST_RUN;
        end else begin
          step_all = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WARMUP - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        valid      = 1'b1;
        seed_ready = 1'b1;
        step_all   = en;
      end
    endcase
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [MAX_W-1:0] CH_SEED = chan_seed(SEED, SEED_STRIDE, c);

    logic             load_c;
    logic [WIDTH-1:0] st_c;

    // Out-of-range channel numbers match no channel and are dropped.
    assign load_c = accept && (seed_ch == SCH_W'(c));

    lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS[WIDTH-1:0]),
      .SEED  (CH_SEED[WIDTH-1:0])
    ) u_core (
      .CLK       (CLK),
      .nRST      (nRST),
      .load      (load_c),
      .load_data (seed_data),
      .step      (step_all),
      .state     (st_c),
      .lockup    (lockup[c])
    );

    assign r[c*WIDTH +: WIDTH] = st_c;
    assign bits[c]             = st_c[WIDTH-1];
  end

endmodule

// File: tb/tb_lfsr_bank.sv
// Self-checking bench for lfsr_bank. Four configurations run one after
// another against a behavioural model of the bank.
module tb_lfsr_bank;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  // dut_a: 64-bit x4 defaults, no warm-up
  logic en_a = 0, sv_a = 0, sr_a, valid_a;
  logic [1:0] sch_a = '0;
  logic [63:0] sd_a = '0;
  logic [255:0] r_a;
  logic [3:0] bits_a, lk_a;
  // dut_b: 8-bit x1 maximal taps, seed 1
  logic en_b = 0, sv_b = 0, sr_b, valid_b;
  logic [0:0] sch_b = '0;
  logic [7:0] sd_b = '0, r_b;
  logic [0:0] bits_b, lk_b;
  // dut_c: defaults with 16-step warm-up
  logic en_c = 0, sv_c = 0, sr_c, valid_c;
  logic [1:0] sch_c = '0;
  logic [63:0] sd_c = '0;
  logic [255:0] r_c;
  logic [3:0] bits_c, lk_c;
  // dut_d: 4-bit x2 with no taps, drains to zero
  logic en_d = 0, sv_d = 0, sr_d, valid_d;
  logic [0:0] sch_d = '0;
  logic [3:0] sd_d = '0;
  logic [7:0] r_d;
  logic [1:0] bits_d, lk_d;

  lfsr_bank #(.WIDTH(64), .NUM_CH(4), .WARMUP(0)) dut_a (
    .CLK(CLK), .nRST(nRST), .en(en_a), .seed_valid(sv_a), .seed_ch(sch_a),
    .seed_data(sd_a), .seed_ready(sr_a), .valid(valid_a), .r(r_a),
    .bits(bits_a), .lockup(lk_a));

  lfsr_bank #(.WIDTH(8), .NUM_CH(1), .TAPS(64'hB8), .SEED(64'h1), .WARMUP(0)) dut_b (
    .CLK(CLK), .nRST(nRST), .en(en_b), .seed_valid(sv_b), .seed_ch(sch_b),
    .seed_data(sd_b), .seed_ready(sr_b), .valid(valid_b), .r(r_b),
    .bits(bits_b), .lockup(lk_b));

  lfsr_bank #(.WIDTH(64), .NUM_CH(4), .WARMUP(16)) dut_c (
    .CLK(CLK), .nRST(nRST), .en(en_c), .seed_valid(sv_c), .seed_ch(sch_c),
    .seed_data(sd_c), .seed_ready(sr_c), .valid(valid_c), .r(r_c),
    .bits(bits_c), .lockup(lk_c));

  lfsr_bank #(.WIDTH(4), .NUM_CH(2), .TAPS(64'h0), .SEED(64'h1),
              .SEED_STRIDE(64'h0), .WARMUP(0)) dut_d (
    .CLK(CLK), .nRST(nRST), .en(en_d), .seed_valid(sv_d), .seed_ch(sch_d),
    .seed_data(sd_d), .seed_ready(sr_d), .valid(valid_d), .r(r_d),
    .bits(bits_d), .lockup(lk_d));

  typedef struct {
    int          w;
    int          nch;
    logic [63:0] taps;
    logic [63:0] seed;
    logic [63:0] stride;
    int          warm;
  } cfg_t;

  function automatic cfg_t get_cfg(input int dut);
    cfg_t k;
    case (dut)
      0:       k = '{64, 4, 64'hD800000000000000, 64'hFEEDBABEDEADBEEF, 64'h9E3779B97F4A7C15, 0};
      1:       k = '{8, 1, 64'hB8, 64'h1, 64'h9E3779B97F4A7C15, 0};
      2:       k = '{64, 4, 64'hD800000000000000, 64'hFEEDBABEDEADBEEF, 64'h9E3779B97F4A7C15, 16};
      default: k = '{4, 2, 64'h0, 64'h1, 64'h0, 0};
    endcase
    return k;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Behavioural model: per-channel state, sticky lockup, and remaining warm-up.
  logic [63:0] m_st [4];
  logic        m_lk [4];
  bit          m_run;
  int          m_warm;

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // Shift left by one, feeding in the parity of the tapped bits.
  function automatic logic [63:0] ref_step(input logic [63:0] s, input int w, input logic [63:0] taps);
    logic [63:0] m = wmask(w);
    logic [63:0] fb = ($countones(s & taps & m) % 2 == 1) ? 64'd1 : 64'd0;
    return ((s << 1) & m) | fb;
  endfunction

  task automatic model_reset(input int dut);
    cfg_t k = get_cfg(dut);
    for (int i = 0; i < 4; i++) begin
      m_st[i] = (k.seed ^ (64'(i) * k.stride)) & wmask(k.w);
      if (m_st[i] == 64'd0) m_st[i] = 64'd1;
      m_lk[i] = 1'b0;
    end
    m_run  = 1'b0;
    m_warm = k.warm;
  endtask

  task automatic model_edge(input int dut, input bit en, input bit sv, input int sch,
                            input logic [63:0] sd);
    cfg_t k = get_cfg(dut);
    bit do_step, take;
    logic [63:0] d = sd & wmask(k.w);
    if (!m_run) begin
      do_step = (m_warm > 0);
      take    = 1'b0;
      if (m_warm > 0) m_warm--;
      if (m_warm == 0) m_run = 1'b1;
    end else begin
      do_step = en;
      take    = sv;
    end
    for (int i = 0; i < k.nch; i++) begin
      if (take && sch == i) begin
        m_st[i] = (d == 64'd0) ? 64'd1 : d;
        m_lk[i] = 1'b0;
      end else if (do_step) begin
        if (m_st[i] == 64'd0) begin
          m_st[i] = 64'd1;
          m_lk[i] = 1'b1;
        end else begin
          m_st[i] = ref_step(m_st[i], k.w, k.taps);
        end
      end
    end
  endtask

  task automatic check_outputs(input int dut, input string tag);
    cfg_t k = get_cfg(dut);
    logic [255:0] er = '0, gr;
    logic [3:0] el = '0, eb = '0, gl, gb;
    logic gv, gs;
    for (int i = 0; i < k.nch; i++) begin
      er |= 256'(m_st[i]) << (i * k.w);
      el[i] = m_lk[i];
      eb[i] = m_st[i][k.w-1];
    end
    case (dut)
      0:       begin gr = r_a;          gl = lk_a;     gb = bits_a;     gv = valid_a; gs = sr_a; end
      1:       begin gr = 256'(r_b);    gl = 4'(lk_b); gb = 4'(bits_b); gv = valid_b; gs = sr_b; end
      2:       begin gr = r_c;          gl = lk_c;     gb = bits_c;     gv = valid_c; gs = sr_c; end
      default: begin gr = 256'(r_d);    gl = 4'(lk_d); gb = 4'(bits_d); gv = valid_d; gs = sr_d; end
    endcase
    check({tag, "_r"}, gr, er);
    check({tag, "_lockup"}, 256'(gl), 256'(el));
    check({tag, "_bits"}, 256'(gb), 256'(eb));
    check({tag, "_valid"}, 256'(gv), 256'(m_run));
    check({tag, "_seed_ready"}, 256'(gs), 256'(m_run));
  endtask

  task automatic drive(input int dut, input bit en, input bit sv, input int sch,
                       input logic [63:0] sd);
    case (dut)
      0:       begin en_a = en; sv_a = sv; sch_a = 2'(sch); sd_a = sd;     end
      1:       begin en_b = en; sv_b = sv; sch_b = 1'(sch); sd_b = 8'(sd); end
      2:       begin en_c = en; sv_c = sv; sch_c = 2'(sch); sd_c = sd;     end
      default: begin en_d = en; sv_d = sv; sch_d = 1'(sch); sd_d = 4'(sd); end
    endcase
  endtask

  task automatic cycle(input int dut, input bit en, input bit sv, input int sch,
                       input logic [63:0] sd, input string tag);
    drive(dut, en, sv, sch, sd);
    @(posedge CLK);
    #1;
    model_edge(dut, en, sv, sch, sd);
    check_outputs(dut, tag);
  endtask

  // One reset edge; pend asserts a reseed request that the reset must override.
  task automatic do_reset(input int dut, input bit pend);
    drive(dut, 1'b1, pend, 0, 64'h5);
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    model_reset(dut);
  endtask

  logic [255:0] held;
  logic [7:0]   held_b;
  bit           seen [256];
  int           distinct;

  initial begin
    // ---- dut_a: reset words, random en/reseed, hold, reseed with zero
    do_reset(0, 1'b0);
    check_outputs(0, "a_reset");
    cycle(0, 1, 0, 0, 64'd0, "a_warm0");
    check("a_first_run_word", 256'(r_a[63:0]), 256'(64'hFEEDBABEDEADBEEF));
    cycle(0, 1, 0, 0, 64'd0, "a_step1");
    check("a_second_word", 256'(r_a[63:0]), 256'(64'hFDDB757DBD5B7DDE));
    for (int i = 0; i < 150; i++) begin
      bit en = 1'($urandom_range(0, 3) != 0);
      bit sv = 1'($urandom_range(0, 3) == 0);
      logic [63:0] sd = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
      cycle(0, en, sv, $urandom_range(0, 3), sd, "a_rand");
    end
    held = r_a;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 64'd0, "a_idle");
      check("a_hold", r_a, held);
    end
    cycle(0, 1, 0, 0, 64'd0, "a_resume");
    check("a_resume_moved", 256'(r_a != held), 256'(1));
    cycle(0, 1, 1, 2, 64'd0, "a_reseed0");
    check("a_ch2_is_one", 256'(r_a[191:128]), 256'(1));
    check("a_ch2_lockup", 256'(lk_a[2]), 256'(0));

    // ---- dut_b: full 255-step period of the 8-bit maximal LFSR
    do_reset(1, 1'b0);
    cycle(1, 1, 0, 0, 64'd0, "b_warm0");
    distinct = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      cycle(1, 1, 0, 0, 64'd0, "b_step");
      if (r_b != 8'd0 && !seen[r_b]) begin
        seen[r_b] = 1'b1;
        distinct++;
      end
    end
    check("b_distinct_states", 256'(distinct), 256'(255));
    check("b_period_255", 256'(r_b), 256'(8'h01));
    held_b = r_b;
    cycle(1, 0, 1, 1, 64'h55, "b_oor");
    check("b_oor_ignored", 256'(r_b), 256'(held_b));

    // ---- dut_c: 16-cycle warm-up, en and reseed ignored meanwhile
    do_reset(2, 1'b0);
    check_outputs(2, "c_warm_cycle1");
    for (int i = 0; i < 16; i++) begin
      held = r_c;
      cycle(2, 1'($urandom_range(0, 1)), 1, $urandom_range(0, 3), {$urandom, $urandom}, "c_warm");
      check("c_r_changes", 256'(r_c != held), 256'(1));
    end
    check("c_valid_cycle17", 256'(valid_c), 256'(1));
    cycle(2, 0, 0, 0, 64'd0, "c_run_idle");

    // ---- dut_d: drain to zero, lockup recovery, reseed, mid-run reset
    do_reset(3, 1'b0);
    cycle(3, 1, 0, 0, 64'd0, "d_warm0");
    for (int i = 0; i < 4; i++) cycle(3, 1, 0, 0, 64'd0, "d_shift");
    check("d_state_zero", 256'(r_d), 256'(8'h00));
    cycle(3, 1, 0, 0, 64'd0, "d_step5");
    check("d_recover", 256'(r_d), 256'(8'h11));
    check("d_lockup_set", 256'(lk_d), 256'(2'b11));
    cycle(3, 1, 1, 0, 64'h3, "d_reseed");
    check("d_reseed_r", 256'(r_d), 256'(8'h23));
    check("d_lockup_cleared", 256'(lk_d), 256'(2'b10));
    do_reset(3, 1'b1);
    check_outputs(3, "d_midrun_reset");
    check("d_reset_r", 256'(r_d), 256'(8'h11));
    check("d_reset_valid", 256'(valid_d), 256'(0));
    cycle(3, 1, 0, 0, 64'd0, "d_warm0b");
    for (int i = 0; i < 4; i++) cycle(3, 1, 0, 0, 64'd0, "d_shiftb");
    cycle(3, 1, 1, 1, 64'd0, "d_simul");
    check("d_simul_lockup", 256'(lk_d), 256'(2'b01));
    check("d_simul_r", 256'(r_d), 256'(8'h11));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
